// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Segment order {A,B,C,D,E,F,G}; entry 15 is written first.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1110011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous display update.
//   state | meaning
//   BLANK | dead time at slot start, anode and segments off
//   SHOW  | selected digit driven if enabled
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LoadValid,
    input  logic [15:0] LoadData,
    output logic        LoadReady,
    input  logic [3:0]  DigitEnable,
    output logic [6:0]  Seg,
    output logic [3:0]  Anode,
    output logic        FrameTick
);

    localparam int              CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    seg_state_t       r_state;
    seg_state_t       w_state_next;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [15:0]      r_disp;
    logic [15:0]      r_pend;
    logic             r_pend_valid;
    logic             r_load_ready;
    logic [6:0]       r_seg;
    logic [3:0]       r_anode;
    logic             r_frame_tick;
    logic             w_slot_last;
    logic             w_frame_end;
    logic             w_accept;
    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;
    logic [6:0]       w_seg_next;
    logic [3:0]       w_anode_next;

    assign w_slot_last = (r_slot_cnt == CNT_LAST);
    assign w_frame_end = w_slot_last && (r_idx == 2'd3);
    assign w_cnt_next  = w_slot_last ? '0 : r_slot_cnt + CNT_ONE;
    assign w_idx_next  = w_slot_last ? r_idx + 2'd1 : r_idx;
    assign w_accept    = LoadValid && r_load_ready;
    assign w_nibble    = r_disp[{w_idx_next, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Outputs are computed for the upcoming cycle so the registered anode,
    // segments and counters always describe the same slot position.
    always_comb begin
        w_state_next = r_state;
        w_anode_next = 4'b0000;
        w_seg_next   = SEG_OFF;
        case (r_state)
            BLANK: if (r_slot_cnt == BLANK_LAST) w_state_next = SHOW;
            SHOW:  if (w_slot_last)              w_state_next = BLANK;
            default: w_state_next = BLANK;
        endcase
        if (w_state_next == SHOW && DigitEnable[w_idx_next]) begin
            w_anode_next = 4'b0001 << w_idx_next;
            w_seg_next   = w_glyph;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= BLANK;
            r_idx        <= 2'd0;
            r_slot_cnt   <= '0;
            r_disp       <= 16'h0000;
            r_pend       <= 16'h0000;
            r_pend_valid <= 1'b0;
            r_load_ready <= 1'b1;
            r_seg        <= SEG_OFF;
            r_anode      <= 4'b0000;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_slot_cnt   <= w_cnt_next;
            r_seg        <= w_seg_next;
            r_anode      <= w_anode_next;
            r_frame_tick <= w_frame_end;
            if (w_frame_end && r_pend_valid) begin
                r_disp       <= r_pend;
                r_pend_valid <= 1'b0;
                r_load_ready <= 1'b1;
            end else if (w_accept) begin
                r_pend       <= LoadData;
                r_pend_valid <= 1'b1;
                r_load_ready <= 1'b0;
            end
        end
    end

    assign Seg       = r_seg;
    assign Anode     = r_anode;
    assign FrameTick = r_frame_tick;
    assign LoadReady = r_load_ready;

endmodule
